// File: rtl/univ_reg_n.sv
// -----------------------------------------------------------------------------
// univ_reg_n
// Parametrised multi-function register: hold, shift right/left, parallel load,
// rotate right/left, count up/down. Successor to the single-bit DFF/DFFSR
// storage cells, used as a datapath register, serial-parallel converter or
// small counter.
//
// Parameters
//   WIDTH    register width, 2..32
//   SET_VAL  value loaded by the synchronous set S
//   RST_VAL  value loaded by the synchronous reset R
//
// Ports
//   C    in   1      clock, rising edge
//   R    in   1      synchronous reset, active-low (highest priority)
//   S    in   1      synchronous set, active-high
//   EN   in   1      clock enable; 0 holds Q and SO, clears TC
//   M    in   3      mode select
//   D    in   WIDTH  parallel load data
//   SIR  in   1      serial in for shift right (enters MSB)
//   SIL  in   1      serial in for shift left (enters LSB)
//   Q    out  WIDTH  register contents
//   SO   out  1      registered bit shifted/rotated out by the last shift op
//   TC   out  1      registered one-cycle pulse after a count step wraps
//   Z    out  1      combinational, Q == 0
// -----------------------------------------------------------------------------
module univ_reg_n #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             C,
    input  logic             R,
    input  logic             S,
    input  logic             EN,
    input  logic [2:0]       M,
    input  logic [WIDTH-1:0] D,
    input  logic             SIR,
    input  logic             SIL,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             TC,
    output logic             Z
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
            $error("univ_reg_n: WIDTH must be in 2..32");
        end
    endgenerate

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic             tc_q, tc_d;

    // Defaults hold Q and SO and drop TC, so TC can only ever be a
    // single-cycle pulse out of a count step. An unknown M lands in the
    // default branch and therefore also holds.
    always_comb begin
        q_d  = q_q;
        so_d = so_q;
        tc_d = 1'b0;
        if (EN) begin
            case (M)
                MODE_HOLD: ;
                MODE_SHR: begin
                    q_d  = {SIR, q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                MODE_SHL: begin
                    q_d  = {q_q[WIDTH-2:0], SIL};
                    so_d = q_q[WIDTH-1];
                end
                MODE_LOAD: begin
                    q_d = D;
                end
                MODE_ROR: begin
                    q_d  = {q_q[0], q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    so_d = q_q[WIDTH-1];
                end
                MODE_INC: begin
                    q_d  = q_q + ONE;
                    tc_d = &q_q;
                end
                MODE_DEC: begin
                    q_d  = q_q - ONE;
                    tc_d = ~|q_q;
                end
                default: ;
            endcase
        end
    end

    // Reset and set sit above the enable so they act regardless of EN/M and
    // leave no residue of an operation in flight.
    always_ff @(posedge C) begin
        if (!R) begin
            q_q  <= RST_VAL;
            so_q <= 1'b0;
            tc_q <= 1'b0;
        end else if (S) begin
            q_q  <= SET_VAL;
            so_q <= 1'b0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            so_q <= so_d;
            tc_q <= tc_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge C) begin
        if (R === 1'b1 && S === 1'b0 && EN === 1'b1 && $isunknown(M)) begin
            $warning("univ_reg_n: unknown mode M=%b with EN=1, holding Q", M);
        end
    end
`endif

    assign Q  = q_q;
    assign SO = so_q;
    assign TC = tc_q;
    assign Z  = (q_q == '0);

endmodule

// File: tb/tb_univ_reg_n.sv
module tb_univ_reg_n;

    logic       C = 1'b0;
    logic       R, S, EN, SIR, SIL;
    logic [2:0] M;
    logic [7:0] D;
    logic [7:0] Q;
    logic       SO, TC, Z;

    int checks = 0;
    int errors = 0;

    univ_reg_n #(.WIDTH(8)) dut (
        .C(C), .R(R), .S(S), .EN(EN), .M(M), .D(D),
        .SIR(SIR), .SIL(SIL), .Q(Q), .SO(SO), .TC(TC), .Z(Z)
    );

    always #5 C = ~C;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic en,
                         input logic [2:0] m, input logic [7:0] d);
        R = r; S = s; EN = en; M = m; D = d;
    endtask

    task automatic load(input logic [7:0] v);
        drive(1, 0, 1, 3'b011, v);
        tick();
        checks++;
        if (Q !== v) begin
            errors++;
            $display("FAIL load: Q=%h expected %h", Q, v);
        end
    endtask

    task automatic test_reset();
        drive(0, 1, 1, 3'b110, 8'h5A);
        SIR = 0; SIL = 0;
        tick();
        tick();
        checks++;
        if ({Q, SO, TC, Z} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: Q=%h SO=%b TC=%b Z=%b expected 00 0 0 1", Q, SO, TC, Z);
        end
    endtask

    task automatic test_shift_right();
        logic [7:0] exp_q [3] = '{8'hD2, 8'hE9, 8'hF4};
        logic       exp_so[3] = '{1'b1, 1'b0, 1'b1};
        load(8'hA5);
        SIR = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 3'b001, 8'h00);
            tick();
            checks++;
            if ({Q, SO, TC} !== {exp_q[i], exp_so[i], 1'b0}) begin
                errors++;
                $display("FAIL shr[%0d]: Q=%h SO=%b TC=%b expected %h %b 0",
                         i, Q, SO, TC, exp_q[i], exp_so[i]);
            end
        end
    endtask

    task automatic test_shift_left();
        logic [7:0] exp_q [3] = '{8'h79, 8'hF3, 8'hE7};
        logic       exp_so[3] = '{1'b0, 1'b0, 1'b1};
        load(8'h3C);
        SIL = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 3'b010, 8'h00);
            tick();
            checks++;
            if ({Q, SO} !== {exp_q[i], exp_so[i]}) begin
                errors++;
                $display("FAIL shl[%0d]: Q=%h SO=%b expected %h %b",
                         i, Q, SO, exp_q[i], exp_so[i]);
            end
        end
        SIL = 0;
    endtask

    task automatic test_rotate_left();
        logic [7:0] exp_q [2] = '{8'h03, 8'h06};
        logic       exp_so[2] = '{1'b1, 1'b0};
        load(8'h81);
        // SO was 1 from the previous shift; load must leave it alone
        checks++;
        if (SO !== 1'b1) begin
            errors++;
            $display("FAIL so_hold_on_load: SO=%b expected 1", SO);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 3'b101, 8'h00);
            tick();
            checks++;
            if ({Q, SO} !== {exp_q[i], exp_so[i]}) begin
                errors++;
                $display("FAIL rol[%0d]: Q=%h SO=%b expected %h %b",
                         i, Q, SO, exp_q[i], exp_so[i]);
            end
        end
    endtask

    task automatic test_rotate_right();
        logic [7:0] exp_q [2] = '{8'h80, 8'h40};
        logic       exp_so[2] = '{1'b1, 1'b0};
        load(8'h01);
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 3'b100, 8'h00);
            tick();
            checks++;
            if ({Q, SO} !== {exp_q[i], exp_so[i]}) begin
                errors++;
                $display("FAIL ror[%0d]: Q=%h SO=%b expected %h %b",
                         i, Q, SO, exp_q[i], exp_so[i]);
            end
        end
    endtask

    task automatic test_count_up();
        logic [7:0] exp_q [3] = '{8'hFF, 8'h00, 8'h01};
        logic       exp_tc[3] = '{1'b0, 1'b1, 1'b0};
        logic       exp_z [3] = '{1'b0, 1'b1, 1'b0};
        // make SO=1 first so a count step that disturbs SO is visible
        load(8'h80);
        drive(1, 0, 1, 3'b101, 8'h00);
        tick();
        load(8'hFE);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 3'b110, 8'h00);
            tick();
            checks++;
            if ({Q, TC, Z, SO} !== {exp_q[i], exp_tc[i], exp_z[i], 1'b1}) begin
                errors++;
                $display("FAIL inc[%0d]: Q=%h TC=%b Z=%b SO=%b expected %h %b %b 1",
                         i, Q, TC, Z, SO, exp_q[i], exp_tc[i], exp_z[i]);
            end
        end
    endtask

    task automatic test_count_down_en();
        logic [7:0] exp_q [2] = '{8'h00, 8'hFF};
        logic       exp_tc[2] = '{1'b0, 1'b1};
        logic       exp_z [2] = '{1'b1, 1'b0};
        load(8'h01);
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 3'b111, 8'h00);
            tick();
            checks++;
            if ({Q, TC, Z} !== {exp_q[i], exp_tc[i], exp_z[i]}) begin
                errors++;
                $display("FAIL dec[%0d]: Q=%h TC=%b Z=%b expected %h %b %b",
                         i, Q, TC, Z, exp_q[i], exp_tc[i], exp_z[i]);
            end
        end
        drive(1, 0, 0, 3'b111, 8'h00);
        tick();
        checks++;
        if ({Q, TC} !== {8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL en_low_count: Q=%h TC=%b expected FF 0", Q, TC);
        end
        drive(1, 0, 0, 3'b001, 8'h00);
        SIR = 0;
        tick();
        checks++;
        if ({Q, SO} !== {8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL en_low_shift: Q=%h SO=%b expected FF 1", Q, SO);
        end
    endtask

    task automatic test_hold_tc();
        load(8'hFF);
        drive(1, 0, 1, 3'b110, 8'h00);
        tick();
        drive(1, 0, 1, 3'b000, 8'h00);
        tick();
        checks++;
        if ({Q, TC} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL hold_tc: Q=%h TC=%b expected 00 0", Q, TC);
        end
    endtask

    task automatic test_priority();
        // reset mid-count on the wrapping step: no TC pulse may leak through
        load(8'hFF);
        drive(0, 1, 1, 3'b110, 8'h00);
        tick();
        checks++;
        if ({Q, SO, TC} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL prio_reset: Q=%h SO=%b TC=%b expected 00 0 0", Q, SO, TC);
        end
        drive(1, 1, 0, 3'b011, 8'h12);
        tick();
        checks++;
        if ({Q, SO, TC, Z} !== {8'hFF, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL prio_set: Q=%h SO=%b TC=%b Z=%b expected FF 0 0 0", Q, SO, TC, Z);
        end
        // set must also clear a pending SO=1 and beat an enabled load
        load(8'h01);
        drive(1, 0, 1, 3'b100, 8'h00);
        tick();
        drive(1, 1, 1, 3'b011, 8'h12);
        tick();
        checks++;
        if ({Q, SO} !== {8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL set_clears_so: Q=%h SO=%b expected FF 0", Q, SO);
        end
    endtask

    initial begin
        drive(0, 0, 0, 3'b000, 8'h00);
        SIR = 0; SIL = 0;
        test_reset();
        test_shift_right();
        test_shift_left();
        test_rotate_left();
        test_rotate_right();
        test_count_up();
        test_count_down_en();
        test_hold_tc();
        test_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
